arm_motion_sequencer: RTL

Parametrised N-axis motion sequencer for the robotic arm. It replaces the fixed three-axis, jump-to-value memory/accelerometer selection with slew-rate-limited motion toward a target. The target comes from an external waypoint ROM (ROM mode) or from a live sensor stream (live mode), and the block walks through waypoints with a programmable dwell. It sits between the debounced user controls and position sources on one side, and the display and LED drivers on the other.

---
 rtl/arm_seq_pkg.sv | 24 ++
 rtl/arm_axis_slew.sv | 38 +++
 rtl/arm_motion_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/arm_seq_pkg.sv
// Shared definitions for the arm motion sequencer.
//   state_t     : sequencer FSM states
//   axis_lsb    : bit offset of an axis inside a packed position bus (axis 0 in LSBs)
//   packed_width: total width of a packed N-axis position bus
package arm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    MOVE,
    DWELL,
    LIVE
  } state_t;

  function automatic int unsigned axis_lsb(input int unsigned axis, input int unsigned axis_width);
    return axis * axis_width;
  endfunction

  function automatic int unsigned packed_width(input int unsigned num_axes, input int unsigned axis_width);
    return num_axes * axis_width;
  endfunction

endpackage

// File: rtl/arm_axis_slew.sv
// Single-axis slew limiter.
//   pos      : current axis position (unsigned)
//   target   : desired axis position (unsigned)
//   tick     : apply one slew step this cycle
//   next_pos : pos moved toward target by min(|target-pos|, MAX_STEP) when tick, else pos
//   equal    : pos == target
module arm_axis_slew #(
  parameter int unsigned AXIS_WIDTH = 10,
  parameter int unsigned MAX_STEP   = 8
) (
  input  logic [AXIS_WIDTH-1:0] pos,
  input  logic [AXIS_WIDTH-1:0] target,
  input  logic                  tick,
  output logic [AXIS_WIDTH-1:0] next_pos,
  output logic                  equal
);

  localparam logic [AXIS_WIDTH-1:0] MAX_STEP_W = AXIS_WIDTH'(MAX_STEP);

  logic signed [AXIS_WIDTH:0] diff;
  logic [AXIS_WIDTH-1:0]      mag;
  logic [AXIS_WIDTH-1:0]      step;

  // The step is clamped to the remaining distance, so the result can
  // neither overshoot nor wrap past either end of the range.
  always_comb begin
    diff     = $signed({1'b0, target}) - $signed({1'b0, pos});
    mag      = diff[AXIS_WIDTH] ? AXIS_WIDTH'(-diff) : diff[AXIS_WIDTH-1:0];
    step     = (mag > MAX_STEP_W) ? MAX_STEP_W : mag;
    next_pos = pos;
    if (tick) begin
      next_pos = diff[AXIS_WIDTH] ? (pos - step) : (pos + step);
    end
  end

  assign equal = (pos == target);

endmodule

// File: rtl/arm_motion_sequencer.sv
// N-axis slew-rate-limited motion sequencer.
// Walks a waypoint ROM (ROM mode) or follows a live target stream (live mode),
// moving every axis by at most MAX_STEP per slew tick.
// Ports:
//   clk, rst (async, active high)
//   start / stop       : single-cycle control pulses (stop has priority)
//   select_source      : 0 = ROM playback, 1 = live target
//   live_pos/live_valid: live target and its capture strobe
//   rom_addr/rom_data  : waypoint ROM port (data valid one cycle after address)
//   pos/pos_valid      : commanded position and one-cycle change strobe
//   busy, at_target, wp_index : status
// Build option: define ARM_SEQ_LOOP_EN to wrap playback from the last waypoint
// back to waypoint 0; otherwise playback ends in IDLE at the last waypoint.
module arm_motion_sequencer
  import arm_seq_pkg::*;
#(
  parameter int unsigned NUM_AXES      = 3,
  parameter int unsigned AXIS_WIDTH    = 10,
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned NUM_WAYPOINTS = 16,
  parameter int unsigned STEP_DIV      = 50_000,
  parameter int unsigned MAX_STEP      = 8,
  parameter int unsigned DWELL_TICKS   = 100
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           select_source,
  input  logic [NUM_AXES*AXIS_WIDTH-1:0] live_pos,
  input  logic                           live_valid,
  output logic [ADDRESS_WIDTH-1:0]       rom_addr,
  input  logic [NUM_AXES*AXIS_WIDTH-1:0] rom_data,
  output logic [NUM_AXES*AXIS_WIDTH-1:0] pos,
  output logic                           pos_valid,
  output logic                           busy,
  output logic                           at_target,
  output logic [ADDRESS_WIDTH-1:0]       wp_index
);

  localparam int unsigned PW    = packed_width(NUM_AXES, AXIS_WIDTH);
  localparam int unsigned PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned DW_W  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [PRE_W-1:0]         PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [DW_W-1:0]          DW_LAST  = DW_W'((DWELL_TICKS == 0) ? 0 : DWELL_TICKS - 1);
  localparam logic [ADDRESS_WIDTH-1:0] WP_LAST  = ADDRESS_WIDTH'(NUM_WAYPOINTS - 1);
`ifdef ARM_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  state_t             state, state_nx;
  logic [PW-1:0]      target;
  logic [PW-1:0]      slew_pos;
  logic [NUM_AXES-1:0] axis_eq;
  logic [PRE_W-1:0]   prescaler;
  logic [DW_W-1:0]    dwell_cnt;
  logic               tick;
  logic               move_tick;
  logic               dwell_done;

  assign tick       = (state inside {MOVE, DWELL, LIVE}) && (prescaler == PRE_LAST);
  assign move_tick  = tick && (state inside {MOVE, LIVE});
  assign dwell_done = (DWELL_TICKS == 0) ? 1'b1 : (tick && (dwell_cnt == DW_LAST));
  assign at_target  = &axis_eq;
  assign busy       = (state != IDLE);
  assign rom_addr   = wp_index;

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    localparam int unsigned LSB = axis_lsb(i, AXIS_WIDTH);
    arm_axis_slew #(
      .AXIS_WIDTH (AXIS_WIDTH),
      .MAX_STEP   (MAX_STEP)
    ) u_slew (
      .pos      (pos[LSB +: AXIS_WIDTH]),
      .target   (target[LSB +: AXIS_WIDTH]),
      .tick     (move_tick),
      .next_pos (slew_pos[LSB +: AXIS_WIDTH]),
      .equal    (axis_eq[i])
    );
  end

  always_comb begin
    state_nx = state;
    if (stop) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (select_source) state_nx = LIVE;
               else if (start)    state_nx = FETCH;
        FETCH: state_nx = select_source ? LIVE : WAIT;
        WAIT:  state_nx = select_source ? LIVE : MOVE;
        MOVE:  if (select_source)  state_nx = LIVE;
               else if (at_target) state_nx = DWELL;
        DWELL: if (select_source) state_nx = LIVE;
               else if (dwell_done) begin
                 state_nx = (wp_index == WP_LAST && !LOOP_EN) ? IDLE : FETCH;
               end
        LIVE:  if (!select_source) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Prescaler phase carries across MOVE->DWELL; it restarts only on entry
  // to MOVE or LIVE and idles at zero outside the slewing states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
    end else if (!(state_nx inside {MOVE, DWELL, LIVE}) ||
                 (state_nx != state && state_nx != DWELL)) begin
      prescaler <= '0;
    end else if (prescaler == PRE_LAST) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 dwell_cnt <= '0;
    else if (state != DWELL) dwell_cnt <= '0;
    else if (tick)           dwell_cnt <= dwell_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_index <= '0;
    end else if (state == IDLE && state_nx == FETCH) begin
      wp_index <= '0;
    end else if (state == DWELL && state_nx == FETCH) begin
      wp_index <= (wp_index == WP_LAST) ? '0 : wp_index + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target <= '0;
    end else if (stop) begin
      target <= pos;
    end else if (state == WAIT && state_nx == MOVE) begin
      target <= rom_data;
    end else if (state == LIVE && live_valid) begin
      target <= live_pos;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos       <= '0;
      pos_valid <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      if (move_tick && !stop) begin
        pos       <= slew_pos;
        pos_valid <= (slew_pos != pos);
      end
    end
  end

endmodule
